// File: rtl/regfile_sb.sv
// regfile_sb: decode-stage register file with two read ports, two write ports, bypass and load scoreboard
//   clk, rst_n               clock, asynchronous active-low reset
//   ra/rb, ra_use/rb_use     read addresses and "operand needed" flags
//   da/db                    combinational read data
//   we_a/wa/wd_a             ALU writeback port
//   we_b/wb/wd_b             load writeback port (wins over A, clears busy)
//   issue_valid/issue_rd     load issue, marks destination busy
//   stall, pending_cnt       decode hold and number of busy registers
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic              ra_use,
  input  logic              rb_use,
  output logic [DATA_W-1:0] da,
  output logic [DATA_W-1:0] db,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wb,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic [ADDR_W:0]   pending_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [ADDR_W:0] cnt_nxt;
  logic ra_busy, rb_busy, a_ok, b_ok;
  assign a_ok = we_a && !(ZERO_REG != 0 && wa == '0);
  assign b_ok = we_b && !(ZERO_REG != 0 && wb == '0);
  always_comb begin
    da = (ZERO_REG != 0 && ra == '0) ? '0 :
         (BYPASS != 0 && we_b && wb == ra) ? wd_b :
         (BYPASS != 0 && we_a && wa == ra) ? wd_a : mem[ra];
    db = (ZERO_REG != 0 && rb == '0) ? '0 :
         (BYPASS != 0 && we_b && wb == rb) ? wd_b :
         (BYPASS != 0 && we_a && wa == rb) ? wd_a : mem[rb];
    ra_busy = busy[ra] && !(BYPASS != 0 && we_b && wb == ra);
    rb_busy = busy[rb] && !(BYPASS != 0 && we_b && wb == rb);
    stall = (ra_use && ra_busy) || (rb_use && rb_busy) ||
            (issue_valid && busy[issue_rd] && !(we_b && wb == issue_rd));
  end
  // a fresh issue supersedes an older load to the same register, so set beats clear
  always_comb begin
    busy_nxt = busy;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_nxt[i] = (issue_valid && issue_rd == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) ? 1'b1 :
                    (we_b && wb == ADDR_W'(i)) ? 1'b0 : busy[i];
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      busy <= '0;
      pending_cnt <= '0;
    end else begin
      if (a_ok) mem[wa] <= wd_a;
      if (b_ok) mem[wb] <= wd_b;
      busy <= busy_nxt;
      pending_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus randomized check of regfile_sb against an array/scoreboard model
module tb_regfile_sb;
  logic clk, rst_n;
  logic [4:0] ra, rb, wa, wb, issue_rd;
  logic ra_use, rb_use, we_a, we_b, issue_valid;
  logic [31:0] wd_a, wd_b, da, db;
  logic stall;
  logic [5:0] pending_cnt;
  int vectors = 0, miscompares = 0;
  logic [31:0] m [32];
  logic [31:0] mb;

  regfile_sb dut (.clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .ra_use(ra_use), .rb_use(rb_use),
    .da(da), .db(db), .we_a(we_a), .wa(wa), .wd_a(wd_a), .we_b(we_b), .wb(wb), .wd_b(wd_b),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .stall(stall), .pending_cnt(pending_cnt));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 0;
    if (we_b && wb == a) return wd_b;
    if (we_a && wa == a) return wd_a;
    return m[a];
  endfunction

  function automatic logic exp_stall();
    logic s;
    s = ra_use && mb[ra] && !(we_b && wb == ra);
    s = s || (rb_use && mb[rb] && !(we_b && wb == rb));
    s = s || (issue_valid && mb[issue_rd] && !(we_b && wb == issue_rd));
    return s;
  endfunction

  task automatic model_reset();
    foreach (m[i]) m[i] = 0;
    mb = 0;
  endtask

  task automatic idle();
    ra = 0; rb = 0; ra_use = 0; rb_use = 0;
    we_a = 0; wa = 0; wd_a = 0; we_b = 0; wb = 0; wd_b = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic pre();
    #1;
    chk("da", da, exp_rd(ra));
    chk("db", db, exp_rd(rb));
    chk("stall", stall, exp_stall());
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (we_a && wa != 0) m[wa] = wd_a;
    if (we_b && wb != 0) m[wb] = wd_b;
    if (we_b) mb[wb] = 0;
    if (issue_valid && issue_rd != 0) mb[issue_rd] = 1;
    #1;
    chk("pending_cnt", pending_cnt, $countones(mb));
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    ra = 5;
    #2;
    chk("rst_da", da, 0);
    chk("rst_cnt", pending_cnt, 0);
    chk("rst_stall", stall, 0);
    #10 rst_n = 1;
    @(posedge clk); #1;

    // async reset mid-cycle
    idle(); we_a = 1; wa = 5; wd_a = 32'hDEADBEEF; issue_valid = 1; issue_rd = 9;
    pre(); edge_step();
    idle(); ra = 5;
    pre();
    chk("r5_written", da, 32'hDEADBEEF);
    chk("r9_pending", pending_cnt, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_da", da, 0);
    chk("async_rst_cnt", pending_cnt, 0);
    #2 rst_n = 1;
    @(posedge clk); #1;

    // zero register
    idle(); we_a = 1; wa = 0; wd_a = 32'hFFFFFFFF; issue_valid = 1; issue_rd = 0; ra_use = 1;
    pre();
    chk("zero_da", da, 0);
    chk("zero_stall", stall, 0);
    edge_step();
    chk("zero_cnt", pending_cnt, 0);
    idle(); pre();
    chk("zero_after", da, 0);
    edge_step();

    // dual write, B wins, bypass
    idle(); we_a = 1; wa = 3; wd_a = 32'h11; we_b = 1; wb = 3; wd_b = 32'h22; ra = 3; rb = 3;
    pre();
    chk("dual_same", da, 32'h22);
    edge_step();
    idle(); ra = 3; pre();
    chk("dual_next", da, 32'h22);
    edge_step();

    // load-use
    idle(); issue_valid = 1; issue_rd = 7; pre(); edge_step();
    chk("lu_cnt1", pending_cnt, 1);
    idle(); ra = 7; ra_use = 1; pre();
    chk("lu_stall", stall, 1);
    edge_step();
    idle(); ra = 7; ra_use = 1; we_b = 1; wb = 7; wd_b = 32'h55; pre();
    chk("lu_wb_stall", stall, 0);
    chk("lu_wb_da", da, 32'h55);
    edge_step();
    chk("lu_cnt0", pending_cnt, 0);
    idle(); ra = 7; ra_use = 1; pre();
    chk("lu_after", stall, 0);
    edge_step();

    // set/clear collision
    idle(); issue_valid = 1; issue_rd = 4; pre(); edge_step();
    idle(); issue_valid = 1; issue_rd = 4; we_b = 1; wb = 4; wd_b = 32'h44; pre();
    chk("col_waw", stall, 0);
    edge_step();
    chk("col_cnt", pending_cnt, 1);
    idle(); rb = 4; rb_use = 1; pre();
    chk("col_busy", stall, 1);
    edge_step();
    idle(); we_b = 1; wb = 4; wd_b = 32'h45; pre(); edge_step();
    chk("col_clr", pending_cnt, 0);

    // fill every register, then drain
    for (int i = 1; i < 32; i++) begin
      idle(); issue_valid = 1; issue_rd = 5'(i); pre(); edge_step();
      chk("fill_cnt", pending_cnt, i);
    end
    idle(); ra = 31; ra_use = 1; pre();
    chk("fill_stall", stall, 1);
    edge_step();
    idle(); issue_valid = 1; issue_rd = 31; pre();
    chk("fill_waw", stall, 1);
    edge_step();
    chk("fill_max", pending_cnt, 31);
    for (int i = 1; i < 32; i++) begin
      idle(); we_b = 1; wb = 5'(i); wd_b = $urandom; pre(); edge_step();
      chk("drain_cnt", pending_cnt, 31 - i);
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      ra = 5'($urandom); rb = 5'($urandom);
      ra_use = 1'($urandom); rb_use = 1'($urandom);
      we_a = 1'($urandom); wa = 5'($urandom); wd_a = $urandom;
      we_b = ($urandom_range(0, 3) == 0); wb = 5'($urandom); wd_b = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0); issue_rd = 5'($urandom);
      if ($urandom_range(0, 3) == 0) ra = wb;
      if ($urandom_range(0, 3) == 0) rb = wa;
      pre(); edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with two combinational read ports, two clocked write ports, write-to-read bypass and a per-register scoreboard of pending load results. It sits in the decode stage of the pipelined MIPS core: port A takes ALU writebacks, port B takes load/multi-cycle writebacks, and the scoreboard produces the decode stall when an operand is still in flight. It generalises the single-write-port register file: width and depth are parametrised, and bypass, reset clearing, dual write and hazard tracking are added.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and issue
- BYPASS, 1, when 1 same-cycle write data is forwarded to read ports

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ra, rb  in  ADDR_W each  read addresses
- ra_use, rb_use  in  1 each  operand actually needed this cycle
- da, db  out  DATA_W each  read data
- we_a  in  1  port A write enable (ALU)
- wa  in  ADDR_W  port A address
- wd_a  in  DATA_W  port A data
- we_b  in  1  port B write enable (load)
- wb  in  ADDR_W  port B address
- wd_b  in  DATA_W  port B data
- issue_valid  in  1  a load is issued this cycle
- issue_rd  in  ADDR_W  destination of the issued load
- stall  out  1  decode must hold
- pending_cnt  out  ADDR_W+1  number of busy registers

## Operation
- Storage: DEPTH x DATA_W array plus busy[DEPTH-1:0]. Reset clears the array and busy to 0, asynchronously.
- Write: at posedge, when we_x=1 the array entry at the addressed register takes the write data. When wa==wb and both enables are 1, port B wins. With ZERO_REG=1, writes to address 0 are dropped.
- Read: da = 0 if ZERO_REG and ra==0. Otherwise, if BYPASS, da is wd_b when we_b and wb==ra, else wd_a when we_a and wa==ra (B takes priority, matching write priority). Otherwise da is the array entry at ra. db is computed the same way from rb.
- Scoreboard, per register i at posedge:
  - set_i = issue_valid & issue_rd==i & !(ZERO_REG & i==0)
  - clr_i = we_b & wb==i
  - busy[i] <= set_i ? 1 : clr_i ? 0 : busy[i]. Set wins over clear, because a new load to the same register supersedes the old one.
  - Port A writes do not touch busy.
- Hazard: ra_busy = busy[ra] & !(BYPASS & we_b & wb==ra). rb_busy is defined the same way from rb.
- stall = (ra_use & ra_busy) | (rb_use & rb_busy) | (issue_valid & busy[issue_rd] & !(we_b & wb==issue_rd)). The last term covers a WAW on a pending load.
- Register 0 is never busy when ZERO_REG=1.
- pending_cnt is a registered population count of busy. At posedge it updates to the count of the next-state busy vector, so it always equals popcount(busy) as visible after that edge.

## Timing
- Reads and stall are combinational, with 0-cycle latency.
- A write is visible through the array from the cycle after the edge. With BYPASS=1 it is also visible in the same cycle; with BYPASS=0 it is not.
- busy is set the cycle after issue, cleared the cycle after the port B write, and bypassed in the writeback cycle when BYPASS=1.
- Reset values: da/db = 0 (all entries 0), stall = 0 when issue_valid=0, pending_cnt = 0.
- Reset asserted mid-operation clears everything immediately. Writes and issue in that cycle are lost.
- Boundary conditions:
  - Address DEPTH-1 is a normal register.
  - pending_cnt reaches DEPTH-1 (ZERO_REG=1) or DEPTH maximum and never wraps.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n=0 asynchronously mid-cycle -> da for ra=5 reads 0 immediately; pending_cnt=0.
- Zero register: we_a=1, wa=0, wd_a=0xFFFFFFFF; issue_valid with issue_rd=0 -> r0 reads 0, stall=0, pending_cnt unchanged.
- Dual write and bypass: we_a(r3, 0x11) and we_b(r3, 0x22) in the same cycle, ra=3 -> da=0x22 in that cycle (BYPASS=1) and 0x22 the next cycle. With BYPASS=0, da shows the old value in that cycle.
- Load-use: issue r7; next cycle ra=7, ra_use=1 -> stall=1 and pending_cnt=1. In the we_b(r7, 0x55) cycle -> stall=0 and da=0x55. The following cycle -> busy cleared and pending_cnt=0.
- Set/clear collision: with busy[4]=1, apply we_b to r4 and issue r4 in the same cycle -> busy[4] stays 1 and pending_cnt stays 1. WAW stall is 0 that cycle because the write clears the old pending load.
- Fill: issue every register 1..31 on consecutive cycles with no writebacks -> pending_cnt=31, then stall=1 on any used operand. Drain with we_b -> count decrements by 1 each cycle to 0.
